// File: rtl/matrix_bank_store.sv
// Bank of DEPTH DIMxDIM matrices with valid tags, dual registered reads,
// full/row writes with write-first bypass and a sequential bank-clear engine.
// Ports: CLK/RST (async, active-high) | clr_req, busy
//   wr_en/wr_mode/wr_idx/wr_row/wr_data | rd_en/rd_idx1/rd_idx2
//   rd_data1/rd_data2/rd_hit1/rd_hit2/rd_valid | err
module matrix_bank_store #(
  parameter int DIM    = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1,
  localparam int MAT_W = DIM * DIM * DATA_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr_req,
  output logic             busy,
  input  logic             wr_en,
  input  logic             wr_mode,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [MAT_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx1,
  input  logic [IDX_W-1:0] rd_idx2,
  output logic [MAT_W-1:0] rd_data1,
  output logic [MAT_W-1:0] rd_data2,
  output logic             rd_hit1,
  output logic             rd_hit2,
  output logic             rd_valid,
  output logic             err
);

  localparam int ROW_B = DIM * DATA_W;
  localparam logic [IDX_W:0] N_ENT =
    (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_d;
  logic             clr_we;

  logic [MAT_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0] tag;

  logic             idle;
  logic             wr_in;
  logic             wr_ok;
  logic [IDX_W-1:0] wr_sel;
  logic [MAT_W-1:0] base;
  logic [MAT_W-1:0] merged;
  logic             rd_ok;

  logic             rd1_in;
  logic             rd2_in;
  logic [IDX_W-1:0] rd1_sel;
  logic [IDX_W-1:0] rd2_sel;
  logic             byp1;
  logic             byp2;
  logic [MAT_W:0]   nx1;
  logic [MAT_W:0]   nx2;

  // FSM: state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        if (ptr == LAST) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    unique case (state)
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
      end
      default: begin
        busy   = 1'b0;
        clr_we = 1'b0;
      end
    endcase
  end

  assign idle   = ~busy;
  assign wr_in  = {1'b0, wr_idx} < N_ENT;
  assign wr_ok  = idle & wr_en & wr_in;
  assign wr_sel = wr_in ? wr_idx : '0;
  assign rd_ok  = idle & rd_en;

  // Rows not being replaced come from the old
  // matrix only if it was valid.
  assign base = tag[wr_sel] ? mem[wr_sel] : '0;

  always_comb begin
    merged = wr_data;
    if (wr_mode) begin
      for (int r = 0; r < DIM; r++) begin
        if (ROW_W'(r) != wr_row) begin
          merged[r*ROW_B +: ROW_B] =
            base[r*ROW_B +: ROW_B];
        end
      end
    end
  end

  // Returns {hit, data}; a same-cycle write to
  // the entry wins over the stored value.
  function automatic logic [MAT_W:0] pick(
    input logic             in_rng,
    input logic             byp,
    input logic             t,
    input logic [MAT_W-1:0] m,
    input logic [MAT_W-1:0] mg
  );
    logic [MAT_W:0] res;
    res = '0;
    if (in_rng) begin
      if (byp) begin
        res = {1'b1, mg};
      end else if (t) begin
        res = {1'b1, m};
      end
    end
    return res;
  endfunction

  assign rd1_in  = {1'b0, rd_idx1} < N_ENT;
  assign rd2_in  = {1'b0, rd_idx2} < N_ENT;
  assign rd1_sel = rd1_in ? rd_idx1 : '0;
  assign rd2_sel = rd2_in ? rd_idx2 : '0;
  assign byp1    = wr_ok & (wr_idx == rd_idx1);
  assign byp2    = wr_ok & (wr_idx == rd_idx2);

  assign nx1 = pick(rd1_in, byp1, tag[rd1_sel],
                    mem[rd1_sel], merged);
  assign nx2 = pick(rd2_in, byp2, tag[rd2_sel],
                    mem[rd2_sel], merged);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag <= '0;
    end else if (clr_we) begin
      tag[ptr] <= 1'b0;
    end else if (wr_ok) begin
      tag[wr_sel] <= 1'b1;
    end
  end

  // Storage is deliberately not reset; tags
  // mask stale contents.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[wr_sel] <= merged;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_hit1  <= 1'b0;
      rd_hit2  <= 1'b0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      err      <= busy & (wr_en | rd_en);
      if (rd_ok) begin
        {rd_hit1, rd_data1} <= nx1;
        {rd_hit2, rd_data2} <= nx2;
      end
    end
  end

endmodule

// File: tb/tb_matrix_bank_store.sv
// Bench for matrix_bank_store: vector table, random traffic
// against an element-level model, clear and reset-abort sequences.
module tb_matrix_bank_store;

  localparam int DIM   = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NE    = DIM * DIM;
  localparam int MW    = NE * DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          clr_req;
  logic          busy;
  logic          wr_en;
  logic          wr_mode;
  logic [3:0]    wr_idx;
  logic [1:0]    wr_row;
  logic [MW-1:0] wr_data;
  logic          rd_en;
  logic [3:0]    rd_idx1;
  logic [3:0]    rd_idx2;
  logic [MW-1:0] rd_data1;
  logic [MW-1:0] rd_data2;
  logic          rd_hit1;
  logic          rd_hit2;
  logic          rd_valid;
  logic          err;

  matrix_bank_store #(
    .DIM(DIM), .DATA_W(DW), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .clr_req(clr_req),
    .busy(busy), .wr_en(wr_en),
    .wr_mode(wr_mode), .wr_idx(wr_idx),
    .wr_row(wr_row), .wr_data(wr_data),
    .rd_en(rd_en), .rd_idx1(rd_idx1),
    .rd_idx2(rd_idx2), .rd_data1(rd_data1),
    .rd_data2(rd_data2), .rd_hit1(rd_hit1),
    .rd_hit2(rd_hit2), .rd_valid(rd_valid),
    .err(err)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // model: element arrays, valid flags, clear progress
  logic [31:0] mm [DEPTH][NE];
  bit          mv [DEPTH];
  bit          m_busy;
  int          m_ptr;
  logic [MW-1:0] e_d1, e_d2;
  logic        e_h1, e_h2, e_v, e_err;

  task automatic chkb(string nm, logic a, logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0b want %0b", nm, a, e);
    end
  endtask

  task automatic chke(string nm, logic [31:0] a,
                      logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic chkw(string nm, logic [MW-1:0] a,
                      logic [MW-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  function automatic logic [MW-1:0] mat_of(int e);
    logic [MW-1:0] v;
    v = '0;
    if (mv[e])
      for (int k = 0; k < NE; k++)
        v[k*DW +: DW] = mm[e][k];
    return v;
  endfunction

  function automatic logic [MW-1:0] pat(
    logic [31:0] b, logic [31:0] s);
    logic [MW-1:0] v;
    for (int k = 0; k < NE; k++)
      v[k*DW +: DW] = b + 32'(k) * s;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mv[i] = 0;
    m_busy = 0;
    m_ptr  = 0;
    e_d1 = '0; e_d2 = '0;
    e_h1 = 0; e_h2 = 0; e_v = 0; e_err = 0;
  endtask

  task automatic model_step();
    int wi;
    logic [31:0] nv [NE];
    e_err = 0;
    e_v   = 0;
    if (m_busy) begin
      e_err = wr_en | rd_en;
      mv[m_ptr] = 0;
      if (m_ptr == DEPTH - 1) begin
        m_busy = 0;
        m_ptr  = 0;
      end else begin
        m_ptr++;
      end
    end else begin
      if (wr_en) begin
        wi = int'(wr_idx);
        for (int k = 0; k < NE; k++) begin
          if (!wr_mode || k / DIM == int'(wr_row))
            nv[k] = wr_data[k*DW +: DW];
          else
            nv[k] = mv[wi] ? mm[wi][k] : 32'd0;
        end
        for (int k = 0; k < NE; k++) mm[wi][k] = nv[k];
        mv[wi] = 1;
      end
      if (rd_en) begin
        e_v  = 1;
        e_d1 = mat_of(int'(rd_idx1));
        e_d2 = mat_of(int'(rd_idx2));
        e_h1 = mv[int'(rd_idx1)];
        e_h2 = mv[int'(rd_idx2)];
      end
      if (clr_req) begin
        m_busy = 1;
        m_ptr  = 0;
      end
    end
  endtask

  task automatic check_all();
    chkb("busy", busy, m_busy);
    chkb("err", err, e_err);
    chkb("rd_valid", rd_valid, e_v);
    chkb("rd_hit1", rd_hit1, e_h1);
    chkb("rd_hit2", rd_hit2, e_h2);
    chkw("rd_data1", rd_data1, e_d1);
    chkw("rd_data2", rd_data2, e_d2);
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_in();
    clr_req = 0; wr_en = 0; wr_mode = 0;
    wr_idx = '0; wr_row = '0; wr_data = '0;
    rd_en = 0; rd_idx1 = '0; rd_idx2 = '0;
  endtask

  task automatic rand_data();
    for (int k = 0; k < NE; k++)
      wr_data[k*DW +: DW] = $urandom;
  endtask

  typedef struct {
    bit we; bit wm; int wi; int wr;
    logic [31:0] b; logic [31:0] s;
    bit re; int r1; int r2;
    bit ev; bit eh1; bit eh2;
    int el; logic [31:0] ev1; logic [31:0] ev2;
  } vec_t;

  localparam logic [31:0] AA = 32'hAAAAAAAA;
  localparam logic [31:0] FV = 32'h55555555;

  vec_t tbl [12];
  int   n;

  initial begin
    tbl[0]  = '{0,0,0,0,0,0, 1,3,5, 1,0,0, 0,0,0};
    tbl[1]  = '{1,0,2,0,1,1, 0,0,0, 0,0,0, 0,0,0};
    tbl[2]  = '{0,0,0,0,0,0, 1,2,2, 1,1,1, 6,7,7};
    tbl[3]  = '{1,1,2,1,AA,0, 1,2,2, 1,1,1, 5,AA,AA};
    tbl[4]  = '{0,0,0,0,0,0, 1,2,2, 1,1,1, 0,1,1};
    tbl[5]  = '{0,0,0,0,0,0, 1,2,2, 1,1,1, 15,16,16};
    tbl[6]  = '{1,1,9,1,AA,0, 0,0,0, 0,1,1, 15,16,16};
    tbl[7]  = '{0,0,0,0,0,0, 1,9,2, 1,1,1, 0,0,1};
    tbl[8]  = '{0,0,0,0,0,0, 1,9,9, 1,1,1, 4,AA,AA};
    tbl[9]  = '{1,0,4,0,FV,0, 1,4,4, 1,1,1, 0,FV,FV};
    tbl[10] = '{0,0,0,0,0,0, 1,4,3, 1,1,0, 3,FV,0};
    tbl[11] = '{0,0,0,0,0,0, 0,0,0, 0,1,0, 3,FV,0};

    idle_in();
    RST = 1;
    model_reset();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_all();
    RST = 0;

    // vector table
    for (int i = 0; i < 12; i++) begin
      idle_in();
      wr_en   = tbl[i].we;
      wr_mode = tbl[i].wm;
      wr_idx  = 4'(tbl[i].wi);
      wr_row  = 2'(tbl[i].wr);
      wr_data = pat(tbl[i].b, tbl[i].s);
      rd_en   = tbl[i].re;
      rd_idx1 = 4'(tbl[i].r1);
      rd_idx2 = 4'(tbl[i].r2);
      cycle();
      chkb("tbl_valid", rd_valid, tbl[i].ev);
      chkb("tbl_hit1", rd_hit1, tbl[i].eh1);
      chkb("tbl_hit2", rd_hit2, tbl[i].eh2);
      chke("tbl_el1", rd_data1[tbl[i].el*DW +: DW],
           tbl[i].ev1);
      chke("tbl_el2", rd_data2[tbl[i].el*DW +: DW],
           tbl[i].ev2);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      idle_in();
      wr_en   = 1'($urandom);
      wr_mode = 1'($urandom);
      wr_idx  = 4'($urandom);
      wr_row  = 2'($urandom);
      rand_data();
      rd_en   = 1'($urandom);
      rd_idx1 = ($urandom % 3 == 0) ? wr_idx
                                    : 4'($urandom);
      rd_idx2 = ($urandom % 3 == 0) ? wr_idx
                                    : 4'($urandom);
      clr_req = ($urandom % 40 == 0);
      cycle();
    end
    idle_in();
    for (int i = 0; i < 20; i++) cycle();

    // fill all, then clear with a read mid-way
    for (int i = 0; i < DEPTH; i++) begin
      idle_in();
      wr_en  = 1;
      wr_idx = 4'(i);
      rand_data();
      cycle();
    end
    idle_in();
    clr_req = 1;
    cycle();
    clr_req = 0;
    n = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      n++;
      rd_en   = (n == 5);
      rd_idx1 = 4'd3;
      rd_idx2 = 4'd3;
      cycle();
      if (n == 5) begin
        chkb("clr_err", err, 1'b1);
        chkb("clr_no_valid", rd_valid, 1'b0);
      end
      rd_en = 0;
    end
    chke("busy_cycles", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      idle_in();
      rd_en   = 1;
      rd_idx1 = 4'(i);
      rd_idx2 = 4'(DEPTH - 1 - i);
      cycle();
      chkb("post_clr_hit", rd_hit1, 1'b0);
      chkw("post_clr_data", rd_data1, '0);
    end

    // reset in the middle of a clear
    for (int i = 0; i < 4; i++) begin
      idle_in();
      wr_en  = 1;
      wr_idx = 4'(i);
      rand_data();
      cycle();
    end
    idle_in();
    clr_req = 1;
    cycle();
    clr_req = 0;
    for (int i = 0; i < 6; i++) cycle();
    RST = 1;
    #1;
    model_reset();
    chkb("rst_busy", busy, 1'b0);
    check_all();
    @(posedge CLK);
    #1;
    RST = 0;
    idle_in();
    wr_en   = 1;
    wr_idx  = 4'd6;
    wr_data = pat(32'h100, 32'd3);
    rd_en   = 1;
    rd_idx1 = 4'd6;
    rd_idx2 = 4'd0;
    cycle();
    chkb("rst_hit1", rd_hit1, 1'b1);
    chkb("rst_hit2", rd_hit2, 1'b0);
    chkw("rst_data1", rd_data1,
         pat(32'h100, 32'd3));
    idle_in();
    rd_en   = 1;
    rd_idx1 = 4'd1;
    rd_idx2 = 4'd6;
    cycle();
    chkb("rst_old_hit", rd_hit1, 1'b0);
    chkb("rst_new_hit", rd_hit2, 1'b1);
    idle_in();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
